// File: rtl/block_acc_pkg.sv
// Shared types and default sizes for the block accumulator slice.
package block_acc_pkg;

   localparam int BLOCK_LEN_DEF = 64;
   localparam int DATA_W_DEF    = 16;
   localparam int ACC_W_DEF     = 32;
   localparam int TIMEOUT_DEF   = 8;
   localparam int CNT_W         = 7;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      COLLECT,
      DONE
   } acc_state_t;

endpackage

// File: rtl/block_acc_dp.sv
// Datapath for the block accumulator: running sum, beat count and
// (when BLOCK_ACC_MAX_EN is defined) running maximum of accepted beats.
module block_acc_dp
   import block_acc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              accept,
   input  logic [DATA_W-1:0] beat_data,
   output logic [ACC_W-1:0]  sum_q,
   output logic [DATA_W-1:0] max_q,
   output logic [CNT_W-1:0]  count_q
);

   // Sum and count grow by one beat per accept; clear has priority so an idle
   // accumulator always starts the next block from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q   <= '0;
         count_q <= '0;
      end else if (clear) begin
         sum_q   <= '0;
         count_q <= '0;
      end else if (accept) begin
         sum_q   <= sum_q + ACC_W'(beat_data);
         count_q <= count_q + CNT_W'(1);
      end
   end

`ifdef BLOCK_ACC_MAX_EN
   // Track the largest accepted beat of the current block (unsigned compare).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_q <= '0;
      end else if (clear) begin
         max_q <= '0;
      end else if (accept && (beat_data > max_q)) begin
         max_q <= beat_data;
      end
   end
`else
   assign max_q = '0;
`endif

endmodule

// File: rtl/block_accumulator.sv
// Block accumulator: drains one block of beats from the upstream multiplier,
// reports sum/max/count, and flags blocks cut short by an idle timeout.
// Optional feature macro: BLOCK_ACC_MAX_EN builds the max-tracking register.
module block_accumulator
   import block_acc_pkg::*;
#(
   parameter int BLOCK_LEN = BLOCK_LEN_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              RDY_acc,
   output logic              EN_blockRead,
   input  logic              VALID_memVal,
   input  logic [DATA_W-1:0] memVal_data,
   output logic [ACC_W-1:0]  sum_out,
   output logic [DATA_W-1:0] max_out,
   output logic [CNT_W-1:0]  count_out,
   output logic              VALID_sum,
   input  logic              ACK_sum,
   output logic              err_short
);

   localparam int              TO_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   acc_state_t      state;
   acc_state_t      next_state;
   logic            clear;
   logic            accept;
   logic            last_beat;
   logic            to_clr;
   logic            to_inc;
   logic            timed_out;
   logic [TO_W-1:0] to_cnt;

   // The beat being accepted now is the final one when the count already
   // holds BLOCK_LEN-1 beats.
   assign last_beat = (count_out == LAST_CNT);

   // State register; reset drops any block in flight back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus the handshake strobes and datapath controls.
   always_comb begin
      next_state   = state;
      RDY_acc      = 1'b0;
      EN_blockRead = 1'b0;
      clear        = 1'b0;
      accept       = 1'b0;
      to_clr       = 1'b0;
      to_inc       = 1'b0;
      timed_out    = 1'b0;
      unique case (state)
         IDLE: begin
            RDY_acc = 1'b1;
            clear   = 1'b1;
            if (start) begin
               next_state = REQ;
            end
         end
         REQ: begin
            EN_blockRead = 1'b1;
            if (VALID_memVal) begin
               accept     = 1'b1;
               next_state = last_beat ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (VALID_memVal) begin
               accept = 1'b1;
               to_clr = 1'b1;
               if (last_beat) begin
                  next_state = DONE;
               end
            end else begin
               to_inc = 1'b1;
               if (to_cnt == TO_LAST) begin
                  timed_out  = 1'b1;
                  next_state = DONE;
               end
            end
         end
         DONE: begin
            if (ACK_sum) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Idle-cycle counter for the mid-block timeout; any accepted beat restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt <= '0;
      end else if (clear || to_clr) begin
         to_cnt <= '0;
      end else if (to_inc) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Result flags are set on entry to DONE and cleared when the consumer acks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         VALID_sum <= 1'b0;
         err_short <= 1'b0;
      end else if ((state != DONE) && (next_state == DONE)) begin
         VALID_sum <= 1'b1;
         err_short <= timed_out;
      end else if ((state == DONE) && (next_state == IDLE)) begin
         VALID_sum <= 1'b0;
         err_short <= 1'b0;
      end
   end

   block_acc_dp #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_dp (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .accept    (accept),
      .beat_data (memVal_data),
      .sum_q     (sum_out),
      .max_q     (max_out),
      .count_q   (count_out)
   );

endmodule

// File: doc/block_accumulator.md
BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

Interface
REQ-001 Parameter BLOCK_LEN, default 64: beats per memory block.
REQ-002 Parameter DATA_W, default 16: beat width.
REQ-003 Parameter ACC_W, default 32: sum width.
REQ-004 Parameter TIMEOUT, default 8: idle cycles tolerated mid-block.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  request to drain one block.
REQ-008 RDY_acc  out  1  high when start will be accepted.
REQ-009 EN_blockRead  out  1  read request to the upstream multiplier.
REQ-010 VALID_memVal  in  1  upstream beat valid.
REQ-011 memVal_data  in  DATA_W  upstream beat data.
REQ-012 sum_out  out  ACC_W  unsigned sum of accepted beats.
REQ-013 max_out  out  DATA_W  unsigned maximum of accepted beats.
REQ-014 count_out  out  7  number of accepted beats.
REQ-015 VALID_sum  out  1  result valid.
REQ-016 ACK_sum  in  1  consumer accepts the result.
REQ-017 err_short  out  1  block ended by timeout with count_out < BLOCK_LEN.

Function
REQ-018 FSM states: IDLE, REQ, COLLECT, DONE.
REQ-019 IDLE: RDY_acc=1; start=1 -> REQ next cycle; accumulators, count and timeout counter cleared.
REQ-020 REQ: EN_blockRead=1, held every cycle until VALID_memVal=1; the beat in that cycle is accepted; -> COLLECT.
REQ-021 COLLECT: EN_blockRead=0; each cycle with VALID_memVal=1: sum += zero-extended beat, max updated, count++, timeout counter cleared.
REQ-022 COLLECT: each cycle with VALID_memVal=0: timeout counter++; reaching TIMEOUT -> DONE with err_short=1.
REQ-023 The BLOCK_LEN-th accepted beat -> DONE next cycle; err_short=0.
REQ-024 DONE: VALID_sum=1; sum_out, max_out, count_out, err_short held stable until ACK_sum=1; then -> IDLE.
REQ-025 Latency: VALID_sum rises the cycle after the final beat is registered.
REQ-026 Arithmetic is unsigned; ACC_W >= DATA_W + log2(BLOCK_LEN), so no overflow or saturation.
REQ-027 VALID_memVal in IDLE or DONE is ignored; no state change.
REQ-028 start outside IDLE is ignored; ACK_sum outside DONE is ignored.
REQ-029 ACK_sum and start in the same DONE cycle: ACK_sum is honoured; start is dropped; a new start is required in IDLE.
REQ-030 Outputs are registered, except RDY_acc and EN_blockRead, which are decoded from state.

Reset
REQ-031 rst=0 forces IDLE immediately, whatever the state, mid-block included.
REQ-032 Reset values: all outputs 0 except RDY_acc=1; sum, max, count and timeout counter are 0.
REQ-033 After rst deasserts, no beat is accepted until a new start.

Configuration
REQ-034 With BLOCK_ACC_MAX_EN defined: max tracking is built and max_out is driven per REQ-021.
REQ-035 Without BLOCK_ACC_MAX_EN: no max register exists and max_out is tied to 0.

Structure
REQ-036 Package block_acc_pkg holds the state enum plus BLOCK_LEN, DATA_W and ACC_W defaults.
REQ-037 Sub-module block_acc_dp holds the sum, max and count registers with clear and accept controls; the FSM and timeout counter stay in the top level.

Verification
REQ-038 start, then 64 consecutive beats of 16'h0003 -> sum_out=192, max_out=3, count_out=64, err_short=0, VALID_sum one cycle after the last beat.
REQ-039 start, VALID_memVal held low 5 cycles -> EN_blockRead stays high for 5 cycles; the first beat drops it the next cycle.
REQ-040 start, 10 beats (values 1..10), then VALID_memVal low 8 cycles -> DONE with count_out=10, sum_out=55, max_out=10, err_short=1.
REQ-041 64 beats of 16'hFFFF -> sum_out=32'h003F_FFC0; ACK_sum withheld 20 cycles -> outputs stable; ACK_sum -> IDLE next cycle.
REQ-042 rst=0 pulsed after 30 beats -> all outputs reset asynchronously; a following start and 64 beats give a correct fresh sum.
REQ-043 Build without BLOCK_ACC_MAX_EN, 64 beats of 16'h0005 -> max_out=0, sum_out=320.
